// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road intersection light controller.
// Lamp triples are packed {red, yellow, green}.
package traffic_pkg;

   typedef enum logic [1:0] {
      S_NSG = 2'd0,
      S_NSY = 2'd1,
      S_EWG = 2'd2,
      S_EWY = 2'd3
   } state_t;

   localparam int unsigned NS_GREEN_TIME_DEF = 32;
   localparam int unsigned EW_GREEN_TIME_DEF = 16;
   localparam int unsigned YELLOW_TIME_DEF   = 4;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   typedef struct packed {
      logic [2:0] ns;
      logic [2:0] ew;
   } lamps_t;

   function automatic lamps_t lamps_for(state_t s);
      lamps_t l;
      case (s)
         S_NSG:   begin l.ns = LAMP_GREEN;  l.ew = LAMP_RED;    end
         S_NSY:   begin l.ns = LAMP_YELLOW; l.ew = LAMP_RED;    end
         S_EWG:   begin l.ns = LAMP_RED;    l.ew = LAMP_GREEN;  end
         S_EWY:   begin l.ns = LAMP_RED;    l.ew = LAMP_YELLOW; end
         default: begin l.ns = LAMP_GREEN;  l.ew = LAMP_RED;    end
      endcase
      return l;
   endfunction

   function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/traffic_controller_if.sv
// Sensor/lamp bundle between the intersection controller and its environment.
// master = sensor/lamp-driver side, slave = controller.
interface traffic_controller_if;

   logic NS_VEHICLE_DETECT;
   logic EW_VEHICLE_DETECT;
   logic NS_RED;
   logic NS_YELLOW;
   logic NS_GREEN;
   logic EW_RED;
   logic EW_YELLOW;
   logic EW_GREEN;

   modport master (
      output NS_VEHICLE_DETECT, EW_VEHICLE_DETECT,
      input  NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN
   );

   modport slave (
      input  NS_VEHICLE_DETECT, EW_VEHICLE_DETECT,
      output NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN
   );

endinterface

// File: rtl/traffic_controller_phase_timer.sv
// Phase timer: clearable, saturating up-counter; expired when cnt reaches dur-1.
// dur is one bit wider than cnt so the full duration value is representable.
module phase_timer #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W:0]   dur,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   last;

   assign last    = dur - 1'b1;
   assign expired = ({1'b0, cnt} == last);

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_controller.sv
// Two-road intersection controller: NS main road (default green), EW side road.
// Moore FSM with registered lamp outputs and a shared phase timer.
module traffic_controller
   import traffic_pkg::*;
#(
   parameter int unsigned NS_GREEN_TIME = NS_GREEN_TIME_DEF,
   parameter int unsigned EW_GREEN_TIME = EW_GREEN_TIME_DEF,
   parameter int unsigned YELLOW_TIME   = YELLOW_TIME_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   traffic_controller_if.slave   bus
);

   localparam int unsigned MAX_TIME = max3(NS_GREEN_TIME, EW_GREEN_TIME, YELLOW_TIME);
   localparam int unsigned CNT_W    = (MAX_TIME > 1) ? $clog2(MAX_TIME) : 1;

   localparam logic [CNT_W:0] NS_DUR = NS_GREEN_TIME[CNT_W:0];
   localparam logic [CNT_W:0] EW_DUR = EW_GREEN_TIME[CNT_W:0];
   localparam logic [CNT_W:0] Y_DUR  = YELLOW_TIME[CNT_W:0];

   state_t         state;
   state_t         next_state;
   logic           advance;
   logic           expired;
   logic [CNT_W:0] dur;
   lamps_t         lamps_q;

   // The timer must clear on the same edge the state moves, so the
   // transition decision is combinational and shared with the timer.
   always_comb begin
      next_state = state;
      advance    = 1'b0;
      dur        = NS_DUR;
      case (state)
         S_NSG: begin
            dur = NS_DUR;
            if (expired && bus.EW_VEHICLE_DETECT) begin
               next_state = S_NSY;
               advance    = 1'b1;
            end
         end
         S_NSY: begin
            dur = Y_DUR;
            if (expired) begin
               next_state = S_EWG;
               advance    = 1'b1;
            end
         end
         S_EWG: begin
            dur = EW_DUR;
            if (expired && (bus.NS_VEHICLE_DETECT || !bus.EW_VEHICLE_DETECT)) begin
               next_state = S_EWY;
               advance    = 1'b1;
            end
         end
         S_EWY: begin
            dur = Y_DUR;
            if (expired) begin
               next_state = S_NSG;
               advance    = 1'b1;
            end
         end
         default: begin
            next_state = S_NSG;
            advance    = 1'b1;
         end
      endcase
   end

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .clear   (rst || advance),
      .enable  (1'b1),
      .dur     (dur),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_NSG;
         lamps_q <= lamps_for(S_NSG);
      end else begin
         state   <= next_state;
         lamps_q <= lamps_for(next_state);
      end
   end

   assign bus.NS_RED    = lamps_q.ns[2];
   assign bus.NS_YELLOW = lamps_q.ns[1];
   assign bus.NS_GREEN  = lamps_q.ns[0];
   assign bus.EW_RED    = lamps_q.ew[2];
   assign bus.EW_YELLOW = lamps_q.ew[1];
   assign bus.EW_GREEN  = lamps_q.ew[0];

endmodule

// File: tb/tb_traffic_controller.sv
// Self-checking bench for traffic_controller: per-cycle scoreboard from an
// elapsed-cycle model, plus scenario tasks measuring phase lengths.
module tb_traffic_controller;

   localparam int B_EWG = 0;
   localparam int B_EWY = 1;
   localparam int B_NSG = 3;
   localparam int B_NSY = 4;
   localparam logic [5:0] L_NSG = 6'b001_100;
   localparam logic [5:0] L_NSY = 6'b010_100;
   localparam logic [5:0] L_EWG = 6'b100_001;
   localparam logic [5:0] L_EWY = 6'b100_010;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   traffic_controller_if bus ();

   traffic_controller #(
      .NS_GREEN_TIME (32),
      .EW_GREEN_TIME (16),
      .YELLOW_TIME   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [5:0] lamps;
   assign lamps = {bus.NS_RED, bus.NS_YELLOW, bus.NS_GREEN,
                   bus.EW_RED, bus.EW_YELLOW, bus.EW_GREEN};

   // Reference model: phase index plus unbounded count of edges spent in it.
   int         m_phase = 0;
   int         m_t     = 0;
   bit         m_valid = 0;
   logic [5:0] exp_q[$];

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_t     = 0;
         m_valid = 1;
      end else if (m_valid) begin
         int  cyc;
         bit  go;
         cyc = m_t + 1;
         case (m_phase)
            0:       go = (cyc >= 32) && bus.EW_VEHICLE_DETECT;
            1:       go = (cyc >= 4);
            2:       go = (cyc >= 16) && (bus.NS_VEHICLE_DETECT || !bus.EW_VEHICLE_DETECT);
            default: go = (cyc >= 4);
         endcase
         if (go) begin
            m_phase = (m_phase + 1) % 4;
            m_t     = 0;
         end else begin
            m_t = m_t + 1;
         end
      end
      if (m_valid) begin
         case (m_phase)
            0:       exp_q.push_back(L_NSG);
            1:       exp_q.push_back(L_NSY);
            2:       exp_q.push_back(L_EWG);
            default: exp_q.push_back(L_EWY);
         endcase
      end
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [5:0] e;
         e = exp_q.pop_front();
         checks++;
         if (lamps !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t lamps=%b expected=%b", $time, lamps, e);
         end
         checks++;
         if ($countones(lamps[5:3]) != 1 || $countones(lamps[2:0]) != 1 ||
             (lamps[5] == 1'b0 && lamps[2] == 1'b0)) begin
            errors++;
            $display("FAIL lamp_safety t=%0t lamps=%b expected one-hot per road, one red", $time, lamps);
         end
      end
   end

   task automatic do_reset(input logic ns, input logic ew);
      @(negedge clk);
      rst = 1'b1;
      bus.NS_VEHICLE_DETECT = ns;
      bus.EW_VEHICLE_DETECT = ew;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_len(input int idx, output int n);
      n = 0;
      while (lamps[idx] === 1'b1 && n < 500) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_lamp(input int idx);
      int k = 0;
      while (lamps[idx] !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 200) begin
         errors++;
         $display("FAIL wait_lamp bit=%0d lamps=%b expected lamp within 200 cycles", idx, lamps);
      end
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b0);
      checks++;
      if (lamps !== L_NSG) begin
         errors++;
         $display("FAIL reset_lamps got=%b expected=%b", lamps, L_NSG);
      end
   endtask

   task automatic test_ns_hold();
      repeat (100) @(negedge clk);
      checks++;
      if (lamps !== L_NSG) begin
         errors++;
         $display("FAIL ns_hold got=%b expected=%b", lamps, L_NSG);
      end
   endtask

   task automatic test_ew_request();
      int n;
      do_reset(1'b0, 1'b1);
      run_len(B_NSG, n);
      checks++;
      if (n != 32) begin errors++; $display("FAIL ew_req_ns_green got=%0d expected=32", n); end
      run_len(B_NSY, n);
      checks++;
      if (n != 4) begin errors++; $display("FAIL ew_req_ns_yellow got=%0d expected=4", n); end
      repeat (25) @(negedge clk);
      checks++;
      if (lamps !== L_EWG) begin errors++; $display("FAIL ew_hold got=%b expected=%b", lamps, L_EWG); end
      bus.EW_VEHICLE_DETECT = 1'b0;
      @(negedge clk);
      run_len(B_EWY, n);
      checks++;
      if (n != 4) begin errors++; $display("FAIL ew_req_ew_yellow got=%0d expected=4", n); end
      checks++;
      if (lamps !== L_NSG) begin errors++; $display("FAIL ew_req_back_ns got=%b expected=%b", lamps, L_NSG); end
   endtask

   task automatic test_both_busy();
      int n;
      int exp_len[6] = '{32, 4, 16, 4, 32, 4};
      int bits[6]    = '{B_NSG, B_NSY, B_EWG, B_EWY, B_NSG, B_NSY};
      do_reset(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         run_len(bits[i], n);
         checks++;
         if (n != exp_len[i]) begin
            errors++;
            $display("FAIL both_busy_phase%0d got=%0d expected=%0d", i, n, exp_len[i]);
         end
      end
   endtask

   task automatic test_pulse();
      do_reset(1'b0, 1'b0);
      repeat (10) @(negedge clk);
      bus.EW_VEHICLE_DETECT = 1'b1;
      @(negedge clk);
      bus.EW_VEHICLE_DETECT = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (lamps !== L_NSG) begin errors++; $display("FAIL pulse_early got=%b expected=%b", lamps, L_NSG); end
      bus.EW_VEHICLE_DETECT = 1'b1;
      @(negedge clk);
      bus.EW_VEHICLE_DETECT = 1'b0;
      checks++;
      if (lamps !== L_NSY) begin errors++; $display("FAIL pulse_late got=%b expected=%b", lamps, L_NSY); end
      do_reset(1'b0, 1'b0);
      repeat (30) @(negedge clk);
      bus.EW_VEHICLE_DETECT = 1'b1;
      @(negedge clk);
      bus.EW_VEHICLE_DETECT = 1'b0;
      checks++;
      if (lamps !== L_NSG) begin errors++; $display("FAIL pulse_cnt30 got=%b expected=%b", lamps, L_NSG); end
      bus.EW_VEHICLE_DETECT = 1'b1;
      @(negedge clk);
      bus.EW_VEHICLE_DETECT = 1'b0;
      checks++;
      if (lamps !== L_NSY) begin errors++; $display("FAIL pulse_cnt31 got=%b expected=%b", lamps, L_NSY); end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset(1'b1, 1'b1);
      wait_lamp(B_EWG);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (lamps !== L_NSG) begin errors++; $display("FAIL rst_in_ewg got=%b expected=%b", lamps, L_NSG); end
      rst = 1'b0;
      run_len(B_NSG, n);
      checks++;
      if (n != 32) begin errors++; $display("FAIL rst_ewg_restart got=%0d expected=32", n); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (lamps !== L_NSG) begin errors++; $display("FAIL rst_in_nsy got=%b expected=%b", lamps, L_NSG); end
      rst = 1'b0;
      run_len(B_NSG, n);
      checks++;
      if (n != 32) begin errors++; $display("FAIL rst_nsy_restart got=%0d expected=32", n); end
   endtask

   initial begin
      bus.NS_VEHICLE_DETECT = 1'b0;
      bus.EW_VEHICLE_DETECT = 1'b0;
      test_reset();
      test_ns_hold();
      test_ew_request();
      test_both_busy();
      test_pulse();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
